// File: rtl/accel_seq.sv
`default_nettype none
// ============================================================================
// Module      : accel_seq
// Description : Host-side sequencer for the two-operand add accelerator:
//               loads operands to memory, runs the accelerator, returns result.
// Revision    : 1.0  initial release
// ============================================================================
module accel_seq #(
  parameter int TIMEOUT = 64,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [DATA_W-1:0] host_a,
  input  logic [DATA_W-1:0] host_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_err,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              acc_comp_enb,
  input  logic              acc_busyb,
  input  logic              acc_done
);

  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_START  = 3'd3,
    S_RUN    = 3'd4,
    S_FETCH  = 3'd5,
    S_CAPT   = 3'd6,
    S_RESP   = 3'd7
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_wr_data;
  logic [DATA_W-1:0] r_result;
  logic              r_err;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_timeout;

  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    host_ready   = 1'b0;
    res_valid    = 1'b0;
    mem_wr_en    = 1'b0;
    mem_rd_en    = 1'b0;
    mem_addr     = '0;
    acc_comp_enb = 1'b1;
    case (r_state)
      S_IDLE: begin
        host_ready = 1'b1;
        if (host_valid) w_next = S_LOAD_A;
      end
      S_LOAD_A: begin
        mem_wr_en = 1'b1;
        w_next    = S_LOAD_B;
      end
      S_LOAD_B: begin
        mem_wr_en = 1'b1;
        mem_addr  = ADDR_W'(1);
        w_next    = S_START;
      end
      S_START: begin
        acc_comp_enb = 1'b0;
        if (acc_busyb) w_next = S_RUN;
      end
      S_RUN: begin
        acc_comp_enb = 1'b0;
        // done takes priority over a timeout landing in the same cycle
        if (acc_done)       w_next = S_FETCH;
        else if (w_timeout) w_next = S_RESP;
      end
      S_FETCH: begin
        mem_rd_en = 1'b1;
        mem_addr  = ADDR_W'(2);
        w_next    = S_CAPT;
      end
      S_CAPT: begin
        w_next = S_RESP;
      end
      S_RESP: begin
        res_valid = 1'b1;
        if (res_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operand A goes straight into the write-data register; B waits one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_b       <= '0;
      r_wr_data <= '0;
      r_result  <= '0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (host_valid) begin
            r_wr_data <= host_a;
            r_b       <= host_b;
          end
        end
        S_LOAD_A: r_wr_data <= r_b;
        S_START: begin
          if (acc_busyb) r_cnt <= '0;
        end
        S_RUN: begin
          if (!acc_done) begin
            if (w_timeout) begin
              r_err    <= 1'b1;
              r_result <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        S_CAPT: begin
          r_result <= mem_rd_data;
          r_err    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign mem_wr_data = r_wr_data;
  assign res_data    = (r_state == S_RESP) ? r_result : '0;
  assign res_err     = (r_state == S_RESP) ? r_err : 1'b0;

endmodule
`default_nettype wire
